// File: rtl/data_sram_pkg.sv
// Shared types and constants for the data-side SRAM responder: FSM states,
// access-size codes, request-queue entry width and the LFSR seed.
package data_sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Queue entry layout, MSB first: {wr, wstrb[3:0], word_idx, wdata[31:0]}.
    function automatic int entry_width(input int addr_width);
        return 1 + 4 + addr_width + 32;
    endfunction

endpackage

// File: rtl/sram_req_fifo.sv
// In-order request queue for the SRAM responder: synchronous FIFO with
// registered count, full/empty flags and a combinational head read.
module sram_req_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 49,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage arrays are deliberately left out of reset; validity is
    // tracked by the pointers, and a reset port would block RAM inference.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// Responder end of the CPU data SRAM interface: queued, in-order accesses to a
// word-wide RAM after a programmable delay. SRAM_RAND_DELAY_EN adds LFSR jitter.
module data_sram_responder
    import data_sram_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int DELAY       = 2,
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int EW = entry_width(ADDR_WIDTH);
    localparam int CW = $clog2(OUTSTANDING + 1);
`ifdef SRAM_RAND_DELAY_EN
    localparam int CNT_W = 5;
`else
    localparam int CNT_W = 4;
`endif

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        delay_load;
    logic [31:0]             rdata_q;
    logic [31:0]             mem_q [2**ADDR_WIDTH];

    logic                    push;
    logic                    pop;
    logic                    access;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CW-1:0]           fifo_count;
    logic [EW-1:0]           push_data;
    logic [EW-1:0]           head_data;

    logic                    head_wr;
    logic [3:0]              head_wstrb;
    logic [ADDR_WIDTH-1:0]   head_idx;
    logic [31:0]             head_wdata;

    // Byte offset, access size and upper address bits play no part in the access.
    logic unused_inputs;
    assign unused_inputs = ^{size, addr[1:0], addr[31:ADDR_WIDTH+2]};

    // Full flag is derived from the registered count, so a pop never frees a slot early.
    assign addr_ok   = !fifo_full;
    assign push      = req && addr_ok;
    assign push_data = {wr, wstrb, addr[ADDR_WIDTH+1:2], wdata};
    assign {head_wr, head_wstrb, head_idx, head_wdata} = head_data;
    assign rdata     = rdata_q;

    sram_req_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (EW)
    ) u_req_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_data),
        .data_o  (head_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

`ifdef SRAM_RAND_DELAY_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign delay_load = CNT_W'(DELAY) + CNT_W'(lfsr_q[1:0]);
`else
    assign delay_load = CNT_W'(DELAY);
`endif

    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        pop     = 1'b0;
        data_ok = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (push || !fifo_empty) begin
                    state_d = WAIT;
                    cnt_d   = delay_load;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                data_ok = 1'b1;
                pop     = 1'b1;
                // Entries left after this pop, counting a same-edge push.
                if (push || (fifo_count > CW'(1))) begin
                    state_d = WAIT;
                    cnt_d   = delay_load;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (access && !head_wr) begin
                rdata_q <= mem_q[head_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (access && head_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (head_wstrb[b]) begin
                    mem_q[head_idx][8*b +: 8] <= head_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: accepted requests go to a scoreboard and are
// retired against a word model on each data_ok. Build with SRAM_RAND_DELAY_EN for jitter.
module tb_data_sram_responder;
    import data_sram_pkg::*;

    localparam int AW    = 12;
    localparam int DLY   = 2;
    localparam int OUTST = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int          acc;
        bit          iso;
    } txn_t;

    txn_t        sb [$];
    logic [31:0] model [int];
    bit          lat_seen [32];

    data_sram_responder #(
        .ADDR_WIDTH  (AW),
        .DELAY       (DLY),
        .OUTSTANDING (OUTST)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wr      (wr),
        .size    (size),
        .addr    (addr),
        .wstrb   (wstrb),
        .wdata   (wdata),
        .addr_ok (addr_ok),
        .data_ok (data_ok),
        .rdata   (rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Retire on data_ok (before logging a same-cycle accept), then log accepts.
    txn_t        mon_t;
    int          mon_lat;
    int          mon_idx;
    logic [31:0] mon_word;
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (data_ok) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_data_ok: cycle %0d with no accepted request outstanding", cyc);
                end else begin
                    mon_t   = sb.pop_front();
                    mon_idx = int'(mon_t.addr[AW+1:2]);
                    mon_lat = cyc - mon_t.acc;
                    if (mon_t.wr) begin
                        mon_word = model.exists(mon_idx) ? model[mon_idx] : 32'hx;
                        for (int b = 0; b < 4; b++)
                            if (mon_t.wstrb[b]) mon_word[8*b +: 8] = mon_t.wdata[8*b +: 8];
                        model[mon_idx] = mon_word;
                    end else if (model.exists(mon_idx)) begin
                        vectors++;
                        if (rdata !== model[mon_idx]) begin
                            miscompares++;
                            $display("FAIL load_data: addr %h got %h expected %h", mon_t.addr, rdata, model[mon_idx]);
                        end
                    end
                    if (mon_t.iso) begin
                        vectors++;
`ifdef SRAM_RAND_DELAY_EN
                        if (mon_lat < DLY + 2 || mon_lat > DLY + 5) begin
`else
                        if (mon_lat != DLY + 2) begin
`endif
                            miscompares++;
                            $display("FAIL latency: addr %h got %0d cycles expected %0d(+0..3 with jitter)", mon_t.addr, mon_lat, DLY + 2);
                        end
                        if (mon_lat >= 0 && mon_lat < 32) lat_seen[mon_lat] = 1'b1;
                    end
                end
            end
            if (req && addr_ok) begin
                sb.push_back('{wr: wr, addr: addr, wstrb: wstrb, wdata: wdata, acc: cyc, iso: (sb.size() == 0)});
            end
        end
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output int acc);
        req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d; size = SIZE_W;
        acc = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (addr_ok) begin
                acc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        if (acc < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: addr %h never accepted", a);
        end
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d responses still outstanding", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0; wr = 1'b0; size = SIZE_W;
        addr = '0; wstrb = '0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors += 3;
        if (data_ok !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_data_ok: got %b expected 0", data_ok);
        end
        if (rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h expected 00000000", rdata);
        end
        if (addr_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_addr_ok: got %b expected 1", addr_ok);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_store_load();
        int t0, t1;
        int resp [$];
        logic [31:0] load_data = 32'h0;
        issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, t0);
        issue(1'b0, 32'h10, 4'h0, 32'h0, t1);
        for (int i = 0; i < 30 && resp.size() < 2; i++) begin
            @(negedge clk);
            if (data_ok) begin
                resp.push_back(cyc);
                load_data = rdata;
            end
        end
        vectors += 2;
        if (resp.size() != 2) begin
            miscompares++;
            $display("FAIL store_load_count: got %0d responses expected 2", resp.size());
        end
        if (load_data !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL store_load_rdata: got %h expected deadbeef", load_data);
        end
`ifndef SRAM_RAND_DELAY_EN
        if (resp.size() == 2) begin
            vectors += 2;
            if (resp[0] != t0 + 4) begin
                miscompares++;
                $display("FAIL store_resp_cycle: got %0d expected %0d", resp[0] - t0, 4);
            end
            if (resp[1] != t0 + 8) begin
                miscompares++;
                $display("FAIL load_resp_cycle: got %0d expected %0d", resp[1] - t0, 8);
            end
        end
`endif
        wait_idle();
    endtask

    task automatic test_partial_strobe();
        int t;
        issue(1'b1, 32'h30, 4'hF, 32'h11223344, t);
        issue(1'b1, 32'h32, 4'b0100, 32'h00AA0000, t);
        issue(1'b0, 32'h30, 4'h0, 32'h0, t);
        wait_idle();
        vectors++;
        if (rdata !== 32'h11AA3344) begin
            miscompares++;
            $display("FAIL partial_strobe: got %h expected 11aa3344", rdata);
        end
    endtask

    task automatic test_wrap();
        int t;
        issue(1'b1, 32'h4000, 4'hF, 32'hCAFEF00D, t);
        issue(1'b0, 32'h0, 4'h0, 32'h0, t);
        wait_idle();
        vectors++;
        if (rdata !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL wrap_around: got %h expected cafef00d", rdata);
        end
    endtask

    task automatic test_full_queue();
        int exp_ok [13] = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
        req = 1'b1; wr = 1'b0; addr = 32'h10; wstrb = 4'h0; wdata = '0; size = SIZE_W;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
`ifndef SRAM_RAND_DELAY_EN
            vectors++;
            if (addr_ok !== exp_ok[i][0]) begin
                miscompares++;
                $display("FAIL full_addr_ok: cycle +%0d got %b expected %0d", i, addr_ok, exp_ok[i]);
            end
`endif
            if (data_ok) begin
                vectors++;
                if (addr_ok !== 1'b0) begin
                    miscompares++;
                    $display("FAIL full_resp_addr_ok: cycle +%0d got %b expected 0", i, addr_ok);
                end
            end
            @(posedge clk); #1;
        end
        req = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int t;
        issue(1'b1, 32'h20, 4'hF, 32'h0, t);
        wait_idle();
        req = 1'b1; wr = 1'b1; addr = 32'h20; wstrb = 4'hF; wdata = 32'h12345678;
        @(negedge clk);
        vectors++;
        if (addr_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_accept: addr_ok got %b expected 1", addr_ok);
        end
        @(posedge clk); #1;
        req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (data_ok !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_data_ok: got %b expected 0 during reset", data_ok);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if (data_ok !== 1'b0) begin
                miscompares++;
                $display("FAIL postreset_data_ok: cycle +%0d got %b expected 0", i, data_ok);
            end
            @(posedge clk); #1;
        end
        issue(1'b0, 32'h20, 4'h0, 32'h0, t);
        wait_idle();
        vectors++;
        if (rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL midreset_store_dropped: got %h expected 00000000", rdata);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] addrs [4] = '{32'h10, 32'h30, 32'h0, 32'h20};
        int t;
        int n;
        int distinct = 0;
`ifdef SRAM_RAND_DELAY_EN
        n = 100;
`else
        n = 12;
`endif
        for (int i = 0; i < 32; i++) lat_seen[i] = 1'b0;
        for (int i = 0; i < n; i++) begin
            issue(1'b0, addrs[i % 4], 4'h0, 32'h0, t);
            wait_idle();
        end
        for (int i = 0; i < 32; i++) if (lat_seen[i]) distinct++;
        vectors++;
`ifdef SRAM_RAND_DELAY_EN
        if (distinct < 2) begin
            miscompares++;
            $display("FAIL jitter_spread: got %0d distinct latencies expected >=2", distinct);
        end
`else
        if (distinct != 1) begin
            miscompares++;
            $display("FAIL fixed_latency_spread: got %0d distinct latencies expected 1", distinct);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_partial_strobe();
        test_wrap();
        test_full_queue();
        test_reset_mid();
        test_sequential();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL final_outstanding: got %0d expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
